// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice walks the operands LSB digit first.
// Optional ovf/zero flags are enabled by defining ADDSUB_SERIAL_FLAGS_EN.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] s_next;
    logic             last;

    assign last = (cnt == LAST_DIG);

    // Operand registers shift right each RUN cycle, so the slice always sees bits [DIGIT-1:0].
    assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // Result digits enter at the top; after NDIG shifts digit 0 sits at the LSB.
    assign s_next = (s_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b ^ {WIDTH{m}};
                        carry <= m;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    s_q   <= s_next;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        c_q   <= dsum[DIGIT];
                        cnt   <= '0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADDSUB_SERIAL_FLAGS_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;
    logic zero_q;

    // MSBs of a and b' are captured at accept because the shifting operands lose them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1] ^ m;
        end else if (state == ST_RUN && last) begin
            ovf_q  <= (a_msb == b_msb) && (s_next[WIDTH-1] != a_msb);
            zero_q <= (s_next == '0);
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign s         = s_q;
    assign c         = c_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: arithmetic reference model plus directed literals,
// backpressure, mid-RUN reset and a DIGIT == WIDTH instance.
module tb_addsub_serial;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;

`ifdef ADDSUB_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
        logic             zero;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    logic             zero;

    logic             in_valid8;
    logic             in_ready8;
    logic [WIDTH-1:0] a8;
    logic [WIDTH-1:0] b8;
    logic             m8;
    logic             out_valid8;
    logic             out_ready8;
    logic [WIDTH-1:0] s8;
    logic             c8;
    logic             ovf8;
    logic             zero8;

    int   n_checks;
    int   n_errors;
    res_t exp_q[$];
    res_t exp_head;
    res_t got;

    addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c(c), .ovf(ovf), .zero(zero)
    );

    addsub_serial #(.WIDTH(WIDTH), .DIGIT(WIDTH)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .m(m8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .c(c8), .ovf(ovf8), .zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow judged by range of the true result.
    function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic mm);
        res_t r;
        int   ures;
        int   sa;
        int   sb;
        int   sres;
        if (mm) begin
            ures = int'(x) - int'(y) + 256;
            r.c  = (x >= y);
        end else begin
            ures = int'(x) + int'(y);
            r.c  = (ures > 255);
        end
        r.s    = ures[7:0];
        sa     = int'($signed(x));
        sb     = int'($signed(y));
        sres   = mm ? (sa - sb) : (sa + sb);
        r.ovf  = FLAGS && ((sres > 127) || (sres < -128));
        r.zero = FLAGS && (r.s == 8'h00);
        return r;
    endfunction

    // Compare process: every DONE cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            check("hs_exclusive", 32'(in_ready && out_valid), 32'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_head = exp_q[0];
                    check("model_s",    32'(s),    32'(exp_head.s));
                    check("model_c",    32'(c),    32'(exp_head.c));
                    check("model_ovf",  32'(ovf),  32'(exp_head.ovf));
                    check("model_zero", 32'(zero), 32'(exp_head.zero));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One full transaction; during a hold the next pair (nx, ny, nm) is offered and must be refused.
    task automatic op(input logic [7:0] x, input logic [7:0] y, input logic mm, input int hold,
                      input logic [7:0] nx, input logic [7:0] ny, input logic nm,
                      output res_t r);
        int waitc;
        a         = x;
        b         = y;
        m         = mm;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        waitc     = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("accept_wait", 32'(waitc < 50), 32'd1);
        exp_q.push_back(model(x, y, mm));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        m        = 1'($urandom);
        waitc    = 0;
        while (!out_valid && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("latency", 32'(waitc), 32'(NDIG));
        r = {s, c, ovf, zero};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = nx;
            b        = ny;
            m        = nm;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_lit(input string name, input res_t r, input logic [7:0] es, input logic ec,
                             input logic eovf, input logic ezero);
        check({name, "_s"},    32'(r.s),    32'(es));
        check({name, "_c"},    32'(r.c),    32'(ec));
        check({name, "_ovf"},  32'(r.ovf),  32'(eovf && FLAGS));
        check({name, "_zero"}, 32'(r.zero), 32'(ezero && FLAGS));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cx, cy, nx, ny;
        logic       cm, nm;

        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        m          = 1'b0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        a8         = '0;
        b8         = '0;
        m8         = 1'b0;

        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s",         32'(s),         32'd0);
        check("rst_c",         32'(c),         32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(8'h5A, 8'h33, 1'b0, 0, 8'h00, 8'h00, 1'b0, got);
        check_lit("add_5a_33", got, 8'h8D, 1'b0, 1'b1, 1'b0);
        op(8'h10, 8'h20, 1'b1, 0, 8'h00, 8'h00, 1'b0, got);
        check_lit("sub_10_20", got, 8'hF0, 1'b0, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b1, 0, 8'h00, 8'h00, 1'b0, got);
        check_lit("sub_80_01", got, 8'h7F, 1'b1, 1'b1, 1'b0);
        op(8'hFF, 8'h01, 1'b0, 0, 8'h00, 8'h00, 1'b0, got);
        check_lit("add_ff_01", got, 8'h00, 1'b1, 1'b0, 1'b1);
        op(8'h37, 8'h37, 1'b1, 0, 8'h00, 8'h00, 1'b0, got);
        check_lit("sub_37_37", got, 8'h00, 1'b1, 1'b0, 1'b1);

        // Backpressure: second pair offered for 5 DONE cycles, then accepted right after release.
        op(8'h3C, 8'h0F, 1'b0, 5, 8'hC4, 8'h3C, 1'b1, got);
        check_lit("bp_first", got, 8'h4B, 1'b0, 1'b0, 1'b0);
        op(8'hC4, 8'h3C, 1'b1, 0, 8'h00, 8'h00, 1'b0, got);
        check_lit("bp_second", got, 8'h88, 1'b1, 1'b0, 1'b0);

        // Reset while digit 2 is being processed.
        a        = 8'hAA;
        b        = 8'h55;
        m        = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_s",         32'(s),         32'd0);
        check("mid_rst_c",         32'(c),         32'd0);
        check("mid_rst_ovf",       32'(ovf),       32'd0);
        check("mid_rst_zero",      32'(zero),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NDIG + 2; i++) begin
            @(posedge clk); #1;
            check("no_residue_out_valid", 32'(out_valid), 32'd0);
        end
        op(8'h01, 8'h01, 1'b0, 0, 8'h00, 8'h00, 1'b0, got);
        check_lit("after_rst", got, 8'h02, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with occasional backpressure.
        cx = 8'($urandom);
        cy = 8'($urandom);
        cm = 1'($urandom);
        for (int i = 0; i < 40; i++) begin
            int hold;
            nx   = 8'($urandom);
            ny   = 8'($urandom);
            nm   = 1'($urandom);
            hold = $urandom_range(0, 2);
            op(cx, cy, cm, hold, nx, ny, nm, got);
            cx = nx;
            cy = ny;
            cm = nm;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // DIGIT == WIDTH: RUN lasts a single cycle.
        a8        = 8'h5A;
        b8        = 8'h33;
        m8        = 1'b0;
        in_valid8 = 1'b1;
        check("d8_in_ready", 32'(in_ready8), 32'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        check("d8_out_valid", 32'(out_valid8), 32'd1);
        check_lit("d8_add_5a_33", {s8, c8, ovf8, zero8}, 8'h8D, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("d8_release_out_valid", 32'(out_valid8), 32'd0);
        check("d8_release_in_ready",  32'(in_ready8),  32'd1);
        a8        = 8'h10;
        b8        = 8'h20;
        m8        = 1'b1;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        check("d8_out_valid2", 32'(out_valid8), 32'd1);
        check_lit("d8_sub_10_20", {s8, c8, ovf8, zero8}, 8'hF0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder/subtractor: the multi-cycle successor of the team's 4-bit ripple add/sub. It accepts one WIDTH-bit operand pair and a mode bit through a valid/ready handshake. It processes DIGIT bits per clock, LSB digit first, through a single DIGIT-wide adder slice, then holds the result and flags until the consumer takes them. It sits between the operand-fetch logic and the result bus wherever area matters more than latency.

## Interface
- WIDTH, 8: operand/result width in bits; ≥ 2.
- DIGIT, 2: bits processed per clock; WIDTH % DIGIT == 0 is required; NDIG = WIDTH/DIGIT.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- m  input  1  mode: 0 = a + b, 1 = a − b.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer takes result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- c  output  1  carry out of MSB; in subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  s == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1.
  - On in_valid && in_ready: latch a, b, m; carry register ← m; digit counter ← 0; go to RUN.
  - Operands present while in_valid is low are ignored.
- RUN, per cycle, with k = digit counter:
  - Compute digit k as a[k] + (b[k] ^ {DIGIT{m}}) + carry.
  - Write the DIGIT-bit result into s digit k; carry ← digit carry-out; k ← k+1.
  - After digit NDIG−1: c ← final carry; compute ovf and zero; go to DONE.
- DONE: out_valid = 1.
  - s, c, ovf and zero are held stable.
  - On out_ready: go to IDLE.
  - in_ready stays 0, so no new operation overlaps an undelivered result.
- Arithmetic: b' = b ^ {WIDTH{m}}.
  - ovf = (a[MSB] == b'[MSB]) && (s[MSB] != a[MSB]).
  - All results are modulo 2^WIDTH; there is no saturation.
- in_valid, a, b and m are don't-care outside IDLE.
- Reset (asynchronous, at any time, including mid-RUN or in DONE): state → IDLE, counter → 0, carry → 0. The in-flight operation is discarded and no result is emitted.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - s = 0
  - c = 0
  - ovf = 0
  - zero = 0
- Latency: with input handshake at clock edge E, out_valid is first high after edge E+NDIG.
  - RUN occupies exactly NDIG cycles.
- Throughput: one operation per NDIG+2 cycles with out_ready held high (IDLE, NDIG×RUN, DONE).
- DONE lasts ≥ 1 cycle; out_valid drops on the edge where out_ready is sampled high.
- in_ready rises in the same cycle that out_valid falls.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- DIGIT == WIDTH: RUN is a single cycle.

## Configuration
- ADDSUB_SERIAL_FLAGS_EN defined:
  - ovf and zero are computed as above and registered on the RUN→DONE transition.
- Not defined:
  - ovf and zero are tied to 0 and their logic is removed.
  - The ports remain, so the interface is unchanged.
  - s and c are unaffected.

## Test plan
WIDTH=8 and DIGIT=2 (NDIG=4) unless stated otherwise; flags are built with the macro defined.
- Add 0x5A + 0x33, m=0 → s=0x8D, c=0, ovf=1, zero=0; out_valid high exactly 4 cycles after accept.
- Subtract 0x10 − 0x20, m=1 → s=0xF0, c=0 (borrow), ovf=0, zero=0.
- Subtract 0x80 − 0x01 → s=0x7F, c=1, ovf=1.
- Add 0xFF + 0x01 → s=0x00, c=1, ovf=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → s/c/ovf/zero stable, in_ready=0, new operands not taken. Then out_ready=1 → IDLE next cycle and the second pair is accepted.
- Reset and single-cycle variants:
  - Pull rst_n low during RUN digit 2 → all outputs 0 and in_ready=1 immediately. After release, a new 0x01 + 0x01 yields 0x02 with no residue from the aborted operation.
  - Repeat one case with DIGIT=8 → 1-cycle RUN.
